// File: rtl/sargantana_icache_mem_ctrl_if.sv
// Request/response bundle between the icache controller FSM (master) and the
// I-cache storage top (slave).
interface sargantana_icache_mem_ctrl_if #(
    parameter int N_WAYS = 4,
    parameter int N_SETS = 64,
    parameter int TAG_W  = 20,
    parameter int LINE_W = 128
);
    localparam int ADDR_W = $clog2(N_SETS);

    logic [N_WAYS-1:0]        tag_req_i;
    logic [N_WAYS-1:0]        data_req_i;
    logic                     tag_we_i;
    logic                     data_we_i;
    logic                     flush_en_i;
    logic                     valid_bit_i;
    logic [TAG_W-1:0]         tag_i;
    logic [LINE_W-1:0]        cline_i;
    logic [ADDR_W-1:0]        addr_i;
    logic                     busy_o;
    logic                     flush_done_o;
    logic                     rd_valid_o;
    logic [N_WAYS*TAG_W-1:0]  tag_way_o;
    logic [N_WAYS*LINE_W-1:0] cline_way_o;
    logic [N_WAYS-1:0]        valid_bit_o;

    modport master (
        output tag_req_i, data_req_i, tag_we_i, data_we_i, flush_en_i,
               valid_bit_i, tag_i, cline_i, addr_i,
        input  busy_o, flush_done_o, rd_valid_o, tag_way_o, cline_way_o, valid_bit_o
    );

    modport slave (
        input  tag_req_i, data_req_i, tag_we_i, data_we_i, flush_en_i,
               valid_bit_i, tag_i, cline_i, addr_i,
        output busy_o, flush_done_o, rd_valid_o, tag_way_o, cline_way_o, valid_bit_o
    );
endinterface

// File: rtl/sargantana_icache_mem_ctrl.sv
// N-way I-cache tag/valid/data storage with registered reads and a sequenced
// valid-bit clear (INIT after reset, FLUSH on request), one set per cycle.
module sargantana_icache_mem_ctrl #(
    parameter int N_WAYS = 4,
    parameter int N_SETS = 64,
    parameter int TAG_W  = 20,
    parameter int LINE_W = 128
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    sargantana_icache_mem_ctrl_if.slave    bus
);
    localparam int ADDR_W = $clog2(N_SETS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                flush_done_q;
    logic                sweep_last;
    logic                sweep_en;
    logic                access_en;
    logic                busy;

    logic [N_WAYS-1:0]   tag_wr, tag_rd, data_wr, data_rd;
    logic [N_WAYS-1:0]   valid_wdata;

    // Storage arrays carry no reset; the valid array is cleared by the sweep.
    logic [TAG_W-1:0]    tag_mem   [N_WAYS][N_SETS];
    logic [LINE_W-1:0]   line_mem  [N_WAYS][N_SETS];
    logic [N_WAYS-1:0]   valid_mem [N_SETS];

    logic [N_WAYS*TAG_W-1:0]  tag_way_p1;
    logic [N_WAYS*LINE_W-1:0] cline_way_p1;
    logic [N_WAYS-1:0]        valid_way_p1;
    logic                     rd_vld_p1;

    assign sweep_last = (cnt_q == ADDR_W'(N_SETS - 1));

    // FSM: state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= INIT;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_done_q <= (state_q == FLUSH) && sweep_last;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.flush_en_i) state_d = FLUSH;
            end
            INIT, FLUSH: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (sweep_last) state_d = IDLE;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM: outputs; flush in IDLE wins over a same-cycle access
    always_comb begin
        busy      = (state_q != IDLE);
        sweep_en  = busy;
        access_en = (state_q == IDLE) && !bus.flush_en_i;
    end

    assign tag_wr  = bus.tag_req_i  & {N_WAYS{access_en &  bus.tag_we_i}};
    assign tag_rd  = bus.tag_req_i  & {N_WAYS{access_en & ~bus.tag_we_i}};
    assign data_wr = bus.data_req_i & {N_WAYS{access_en &  bus.data_we_i}};
    assign data_rd = bus.data_req_i & {N_WAYS{access_en & ~bus.data_we_i}};

    assign valid_wdata = (valid_mem[bus.addr_i] & ~tag_wr)
                       | (tag_wr & {N_WAYS{bus.valid_bit_i}});

    always_ff @(posedge clk_i) begin
        for (int w = 0; w < N_WAYS; w++) begin
            if (tag_wr[w])  tag_mem[w][bus.addr_i]  <= bus.tag_i;
            if (data_wr[w]) line_mem[w][bus.addr_i] <= bus.cline_i;
        end
        if (sweep_en)
            valid_mem[cnt_q] <= '0;
        else if (|tag_wr)
            valid_mem[bus.addr_i] <= valid_wdata;
    end

    // Read stage p1: per-way registered outputs, untouched ways hold
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag_way_p1   <= '0;
            cline_way_p1 <= '0;
            valid_way_p1 <= '0;
            rd_vld_p1    <= 1'b0;
        end else begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (tag_rd[w]) begin
                    tag_way_p1[w*TAG_W +: TAG_W] <= tag_mem[w][bus.addr_i];
                    valid_way_p1[w]              <= valid_mem[bus.addr_i][w];
                end
                if (data_rd[w])
                    cline_way_p1[w*LINE_W +: LINE_W] <= line_mem[w][bus.addr_i];
            end
            rd_vld_p1 <= |{tag_rd, data_rd};
        end
    end

    assign bus.busy_o       = busy;
    assign bus.flush_done_o = flush_done_q;
    assign bus.rd_valid_o   = rd_vld_p1;
    assign bus.tag_way_o    = tag_way_p1;
    assign bus.cline_way_o  = cline_way_p1;
    assign bus.valid_bit_o  = valid_way_p1;

endmodule
